// File: rtl/vx_ibuffer_issue_arb.sv
// vx_ibuffer_issue_arb: round-robin pick of one per-warp ibuffer stream per cycle,
// registered into a 2-entry skid stage (head = output register, tail = skid register).
// in_ready depends only on registered state, never on out_ready.
module vx_ibuffer_issue_arb #(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = 128,
    parameter int WIS_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_WARPS-1:0]             in_valid,
    input  logic [NUM_WARPS*DATA_WIDTH-1:0]  in_data,
    output logic [NUM_WARPS-1:0]             in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [WIS_W-1:0]                 out_wis,
    input  logic                             out_ready,
    output logic                             busy
);

    logic [1:0]            count;
    logic [WIS_W-1:0]      rr_ptr, rr_next;
    logic [WIS_W-1:0]      grant_idx;
    logic                  grant_vld;
    logic [WIS_W-1:0]      head_wis, tail_wis;
    logic [DATA_WIDTH-1:0] head_data, tail_data, grant_data;
    logic                  push, pop;

    // Find the first valid warp scanning upward from rr_ptr with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
            if (!grant_vld && in_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = WIS_W'(idx);
            end
        end
    end

    // A grant is only issued while the stage has a free slot; reset gates it off.
    assign push       = grant_vld && (count != 2'd2) && reset_n;
    assign pop        = (count != 2'd0) && out_ready;
    assign grant_data = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign rr_next    = (grant_idx == WIS_W'(NUM_WARPS-1)) ? '0 : grant_idx + 1'b1;

    // One-hot accept to the winning warp.
    always_comb begin
        in_ready = '0;
        if (push) in_ready[grant_idx] = 1'b1;
    end

    // Skid stage and round-robin pointer; head always holds the oldest entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= 2'd0;
            rr_ptr    <= '0;
            head_data <= '0;
            head_wis  <= '0;
            tail_data <= '0;
            tail_wis  <= '0;
        end else begin
            if (push) rr_ptr <= rr_next;
            case (count)
                2'd0: begin
                    if (push) begin
                        head_data <= grant_data;
                        head_wis  <= grant_idx;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // head drains while the new record takes its place
                        head_data <= grant_data;
                        head_wis  <= grant_idx;
                    end else if (push) begin
                        tail_data <= grant_data;
                        tail_wis  <= grant_idx;
                        count     <= 2'd2;
                    end else if (pop) begin
                        count     <= 2'd0;
                    end
                end
                default: begin
                    // full: no push possible, pop promotes the skid entry
                    if (pop) begin
                        head_data <= tail_data;
                        head_wis  <= tail_wis;
                        count     <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign out_valid = (count != 2'd0);
    assign busy      = (count != 2'd0);
    assign out_data  = head_data;
    assign out_wis   = head_wis;

endmodule

// File: tb/tb_vx_ibuffer_issue_arb.sv
// Bench for vx_ibuffer_issue_arb: hand-derived vector table, directed corner sequences,
// and a random phase checked against a queue-based reference model.
module tb_vx_ibuffer_issue_arb;

    localparam int NW = 4;
    localparam int DW = 128;

    logic           clk, reset_n;
    logic [NW-1:0]  in_valid, in_ready;
    logic [NW*DW-1:0] in_data;
    logic           out_valid, out_ready, busy;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_wis;
    logic [DW-1:0]  wdata [NW];

    vx_ibuffer_issue_arb #(.NUM_WARPS(NW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_wis(out_wis), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int w = 0; w < NW; w++) in_data[w*DW +: DW] = wdata[w];
    end

    typedef struct {
        logic [1:0]   wis;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] wis;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    ent_t m_q[$];     // reference skid-stage contents, oldest first
    ent_t obs_q[$];   // records seen leaving the DUT
    int   m_rr = 0;
    logic [3:0] last_rdy;
    logic stalled = 1'b0;
    logic [DW-1:0] prev_data;
    int   wt [NW];
    int   max_wt = 0;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_grant(input logic [3:0] iv);
        if (m_q.size() >= 2) return -1;
        for (int i = 0; i < NW; i++) begin
            int w;
            w = (m_rr + i) % NW;
            if (iv[w]) return w;
        end
        return -1;
    endfunction

    // One clock: check at the negedge against the model, then advance the model past the posedge.
    task automatic tick();
        int g;
        logic [3:0] er;
        logic do_pop;
        ent_t e;
        @(negedge clk);
        g  = m_grant(in_valid);
        er = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", DW'(in_ready), DW'(er));
        chk("out_valid", DW'(out_valid), DW'(m_q.size() != 0));
        chk("busy", DW'(busy), DW'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0].data);
            chk("out_wis", DW'(out_wis), DW'(m_q[0].wis));
        end
        if (stalled) chk("stall_hold", out_data, prev_data);
        stalled   = out_valid && !out_ready;
        prev_data = out_data;
        last_rdy  = in_ready;
        if (out_valid && out_ready) obs_q.push_back('{out_wis, out_data});
        for (int w = 0; w < NW; w++) begin
            if (!in_valid[w] || g == w) wt[w] = 0;
            else if (g >= 0) wt[w]++;
            if (wt[w] > max_wt) max_wt = wt[w];
        end
        do_pop = (m_q.size() != 0) && out_ready;
        if (g >= 0) e = '{2'(g), wdata[g]};
        @(posedge clk);
        #1;
        if (do_pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(e);
            m_rr = (g + 1) % NW;
        end
    endtask

    initial begin
        int seq;
        // Hand-derived: 1111 round robin from empty, then 1010, then drain.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd3};
        tbl[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        for (int w = 0; w < NW; w++) begin
            wt[w]    = 0;
            wdata[w] = DW'(32'hC0DE_0000 + w);
        end

        // Reset with all warps requesting
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", DW'(in_ready), '0);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_busy", DW'(busy), '0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Vector table
        for (int r = 0; r < 11; r++) begin
            in_valid  = tbl[r].iv;
            out_ready = tbl[r].ordy;
            #2;
            chk("tbl_in_ready", DW'(in_ready), DW'(tbl[r].rdy));
            chk("tbl_out_valid", DW'(out_valid), DW'(tbl[r].ov));
            if (tbl[r].ov) chk("tbl_out_wis", DW'(out_wis), DW'(tbl[r].wis));
            tick();
        end

        // Backpressure: fill both entries, then drain in order
        obs_q.delete();
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        wdata[0]  = DW'(32'hA);
        tick();
        wdata[0]  = DW'(32'hB);
        tick();
        wdata[0]  = DW'(32'hC);
        tick();
        chk("full_block", DW'(last_rdy), '0);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 4'b0000;
        tick();
        tick();
        chk("bp_count", DW'(obs_q.size()), DW'(3));
        if (obs_q.size() == 3) begin
            chk("bp_first", obs_q[0].data, DW'(32'hA));
            chk("bp_second", obs_q[1].data, DW'(32'hB));
            chk("bp_third", obs_q[2].data, DW'(32'hC));
        end

        // Async reset while full, with rr_ptr away from 0
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        wdata[0]  = DW'(32'hD);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", DW'(out_valid), '0);
        chk("arst_busy", DW'(busy), '0);
        chk("arst_in_ready", DW'(in_ready), '0);
        m_q.delete();
        m_rr    = 0;
        stalled = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        chk("arst_first_grant", DW'(last_rdy), DW'(4'b0001));
        in_valid = 4'b0000;
        tick();
        tick();

        // Push/pop at count==1: warp2 streams 1..8 with out_ready toggling
        obs_q.delete();
        seq      = 1;
        in_valid = 4'b0100;
        wdata[2] = DW'(1);
        for (int c = 0; c < 60; c++) begin
            out_ready = (c % 2 == 0);
            tick();
            if (in_valid[2] && last_rdy[2]) begin
                seq++;
                if (seq <= 8) wdata[2] = DW'(seq);
                else in_valid = 4'b0000;
            end
        end
        chk("pp_count", DW'(obs_q.size()), DW'(8));
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            chk("pp_data", obs_q[i].data, DW'(i + 1));
            chk("pp_wis", DW'(obs_q[i].wis), DW'(2));
        end

        // Random valid/ready against the model; producers hold until accepted
        seq = 100;
        for (int c = 0; c < 10000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            for (int w = 0; w < NW; w++) begin
                if (!in_valid[w] || last_rdy[w]) begin
                    in_valid[w] = ($urandom_range(0, 2) != 0);
                    if (in_valid[w]) begin
                        wdata[w] = DW'({w[7:0], 24'(seq)});
                        seq++;
                    end
                end
            end
        end
        chk("starvation_bound", DW'(max_wt < NW), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
